capture_engine_of_verifla: RTL

- Parametrised capture core for the next-generation on-chip logic analyser.
- Samples a DATA_W-bit probe bus and run-length encodes it into a circular buffer through memory write port A.
- Supports a programmable masked trigger with three modes and a fixed pre-trigger window.
- On completion, hands the buffer to the send-capture block through the sc_run / ack_sc_run / sc_done handshake.

---
 rtl/capture_engine_of_verifla.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/capture_engine_of_verifla.sv
// Run-length-encoding capture core: probe sampling, masked trigger,
// circular buffer write port and send-capture handoff.
module capture_engine_of_verifla #(
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int PRETRIG = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sys_run,
  input  logic                    user_run,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [DATA_W-1:0]       trig_value,
  input  logic [DATA_W-1:0]       trig_mask,
  input  logic [1:0]              trig_mode,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [CNT_W+DATA_W-1:0] mem_data,
  output logic                    mem_wen,
  output logic                    sc_run,
  input  logic                    ack_sc_run,
  input  logic                    sc_done,
  output logic [ADDR_W-1:0]       first_addr,
  output logic [ADDR_W-1:0]       trig_addr,
  output logic                    busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [ADDR_W-1:0] PT = ADDR_W'(PRETRIG);

  if (PRETRIG < 0 || PRETRIG >= DEPTH) begin : g_bad_pretrig
    $error("PRETRIG must lie in 0..DEPTH-1");
  end

  typedef enum logic [2:0] {
    IDLE, PRE, ARMED, POST, HANDOFF, WAIT_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] words;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] last;
  logic              first;
  logic              arm_first;
  logic              prev_hit;

  logic              hit;
  logic              fire;
  logic              new_word;
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W-1:0] waddr;
  logic [CNT_W-1:0]  cnt_n;

  always_comb begin
    hit = ((data_in ^ trig_value) & trig_mask) == '0;
    unique case (trig_mode)
      2'd1:    fire = hit && !prev_hit;
      2'd2:    fire = arm_first;
      default: fire = hit;
    endcase
    new_word = first || (data_in != last) || (cnt == CMAX)
            || (state == ARMED && fire);
    nxt   = addr + 1'b1;
    waddr = first ? '0 : (new_word ? nxt : addr);
    cnt_n = new_word ? CNT_W'(1) : cnt + 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      words      <= '0;
      cnt        <= '0;
      last       <= '0;
      first      <= 1'b0;
      arm_first  <= 1'b0;
      prev_hit   <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wen    <= 1'b0;
      sc_run     <= 1'b0;
      first_addr <= '0;
      trig_addr  <= '0;
    end else begin
      mem_wen <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sys_run || user_run) begin
            state     <= (PRETRIG == 0) ? ARMED : PRE;
            words     <= '0;
            first     <= 1'b1;
            arm_first <= 1'b1;
            prev_hit  <= 1'b0;
          end
        end
        PRE, ARMED, POST: begin
          last  <= data_in;
          first <= 1'b0;
          // stop before a new word would overwrite the oldest pre-trigger word
          if (state == POST && new_word && nxt == first_addr) begin
            state  <= HANDOFF;
            sc_run <= 1'b1;
          end else begin
            addr     <= waddr;
            cnt      <= cnt_n;
            mem_addr <= waddr;
            mem_data <= {cnt_n, data_in};
            mem_wen  <= 1'b1;
            if (state == PRE && new_word) begin
              words <= words + 1'b1;
              if (words + 1'b1 == PT) begin
                state     <= ARMED;
                arm_first <= 1'b1;
                prev_hit  <= 1'b0;
              end
            end
            if (state == ARMED) begin
              arm_first <= 1'b0;
              prev_hit  <= hit;
              if (fire) begin
                trig_addr  <= waddr;
                first_addr <= waddr - PT;
                state      <= POST;
              end
            end
          end
        end
        HANDOFF: begin
          if (ack_sc_run) begin
            sc_run <= 1'b0;
            state  <= sc_done ? IDLE : WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (sc_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
